memory_unit: RTL and testbench

Word-addressed 2048 x 16 data/instruction memory that sits directly downstream of the accumulator CPU's memory port, serving its fetch, operand-read and store cycles. After reset it first runs a program-load phase, in which a host streams words in over a valid/ready port into consecutive addresses from 0. It then asserts `cpuRun` and serves the CPU. Memory contents are not cleared by reset.

---
 rtl/memory_unit.sv | 120 ++++++++++++
 tb/tb_memory_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// Word-addressed program/data memory for the accumulator CPU.
// Host streams a program in after reset, then the CPU port is served.
module memory_unit #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic [AW-1:0] memoryAddress,
  input  logic [15:0]   dataOut,
  input  logic          readSignal,
  input  logic          writeSignal,
  output logic [15:0]   memoryData,
  input  logic          loadValid,
  input  logic [15:0]   loadData,
  input  logic          loadLast,
  output logic          loadReady,
  output logic          cpuRun,
  output logic          loadOverflow
);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [15:0]   mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] loadAddr_q, loadAddr_d;
  logic [15:0]   memoryData_q, memoryData_d;
  logic          loadReady_q, loadReady_d;
  logic          cpuRun_q, cpuRun_d;
  logic          overflow_q, overflow_d;

  logic          accept;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [15:0]   wrData;

  // Host handshake is only live once loadReady has been raised in LOAD.
  assign accept = (state_q == LOAD) && loadValid && loadReady_q;

  // Select the single write port source: host during load, CPU in run.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = loadAddr_q;
    wrData = loadData;
    if (state_q == LOAD) begin
      wrEn = accept;
    end else begin
      wrEn   = writeSignal;
      wrAddr = memoryAddress;
      wrData = dataOut;
    end
  end

  // Next-state logic for the load/run sequencer and its registered outputs.
  always_comb begin
    state_d      = state_q;
    loadAddr_d   = loadAddr_q;
    memoryData_d = memoryData_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          loadAddr_d = loadAddr_q + AW'(1);
          if (loadLast) begin
            state_d = RUN;
          end else if (loadAddr_q == LAST_ADDR) begin
            state_d    = RUN;
            overflow_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (readSignal && !writeSignal) begin
          memoryData_d = mem[memoryAddress];
        end
      end
      default: state_d = LOAD;
    endcase
    loadReady_d = (state_d == LOAD);
    cpuRun_d    = (state_d == RUN);
  end

  // Sequencer state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= LOAD;
      loadAddr_q   <= '0;
      memoryData_q <= '0;
      loadReady_q  <= 1'b0;
      cpuRun_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      loadAddr_q   <= loadAddr_d;
      memoryData_q <= memoryData_d;
      loadReady_q  <= loadReady_d;
      cpuRun_q     <= cpuRun_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign memoryData   = memoryData_q;
  assign loadReady    = loadReady_q;
  assign cpuRun       = cpuRun_q;
  assign loadOverflow = overflow_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: load phase, CPU port table,
// reset during load/run and load overflow.
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] memoryAddress;
  logic [15:0] dataOut;
  logic        readSignal;
  logic        writeSignal;
  logic [15:0] memoryData;
  logic        loadValid;
  logic [15:0] loadData;
  logic        loadLast;
  logic        loadReady;
  logic        cpuRun;
  logic        loadOverflow;

  int checks = 0;
  int errors = 0;

  memory_unit #(.DEPTH(2048), .AW(11)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .memoryAddress (memoryAddress),
    .dataOut       (dataOut),
    .readSignal    (readSignal),
    .writeSignal   (writeSignal),
    .memoryData    (memoryData),
    .loadValid     (loadValid),
    .loadData      (loadData),
    .loadLast      (loadLast),
    .loadReady     (loadReady),
    .cpuRun        (cpuRun),
    .loadOverflow  (loadOverflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [10:0] addr;
    logic [15:0] dout;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [10:0] a);
    memoryAddress = a;
    readSignal    = 1'b1;
    writeSignal   = 1'b0;
    step();
    readSignal    = 1'b0;
  endtask

  logic [15:0] words [4];
  int accepts;

  initial begin
    vecs[0]  = '{"rd1",      1, 0, 11'd1, 16'h0000, 16'h3006};
    vecs[1]  = '{"rd1_hold", 1, 0, 11'd1, 16'h0000, 16'h3006};
    vecs[2]  = '{"rd0",      1, 0, 11'd0, 16'h0000, 16'h1005};
    vecs[3]  = '{"rd2",      1, 0, 11'd2, 16'h0000, 16'h2007};
    vecs[4]  = '{"wr7_a",    0, 1, 11'd7, 16'hFFFB, 16'h2007};
    vecs[5]  = '{"wr7_b",    0, 1, 11'd7, 16'hFFFB, 16'h2007};
    vecs[6]  = '{"rd7",      1, 0, 11'd7, 16'h0000, 16'hFFFB};
    vecs[7]  = '{"prio3",    1, 1, 11'd3, 16'h00AA, 16'hFFFB};
    vecs[8]  = '{"idle",     0, 0, 11'd0, 16'h0000, 16'hFFFB};
    vecs[9]  = '{"rd3",      1, 0, 11'd3, 16'h0000, 16'h00AA};
    vecs[10] = '{"wr3",      0, 1, 11'd3, 16'h1234, 16'h00AA};
    vecs[11] = '{"raw3",     1, 0, 11'd3, 16'h0000, 16'h1234};

    words[0] = 16'h1005;
    words[1] = 16'h3006;
    words[2] = 16'h2007;
    words[3] = 16'h5555;

    resetN        = 1'b0;
    memoryAddress = '0;
    dataOut       = '0;
    readSignal    = 1'b0;
    writeSignal   = 1'b0;
    loadValid     = 1'b0;
    loadData      = '0;
    loadLast      = 1'b0;

    #12;
    chk("rst_memoryData", memoryData, 16'h0000);
    chk("rst_loadReady", 16'(loadReady), 16'h0);
    chk("rst_cpuRun", 16'(cpuRun), 16'h0);
    chk("rst_overflow", 16'(loadOverflow), 16'h0);
    resetN = 1'b1;
    #1;
    chk("ready_before_edge", 16'(loadReady), 16'h0);
    step();
    chk("ready_after_edge", 16'(loadReady), 16'h1);

    // three-word program plus one word that must be refused
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      loadValid = 1'b1;
      loadData  = words[i];
      loadLast  = (i == 2);
      if (loadReady) accepts++;
      step();
    end
    loadValid = 1'b0;
    loadLast  = 1'b0;
    chk("accept_count", 16'(accepts), 16'd3);
    chk("load_ready_low", 16'(loadReady), 16'h0);
    chk("load_cpuRun", 16'(cpuRun), 16'h1);
    chk("load_no_ovf", 16'(loadOverflow), 16'h0);
    chk("load_memData0", memoryData, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      memoryAddress = vecs[i].addr;
      dataOut       = vecs[i].dout;
      readSignal    = vecs[i].rd;
      writeSignal   = vecs[i].wr;
      step();
      chk(vecs[i].name, memoryData, vecs[i].exp);
    end
    readSignal  = 1'b0;
    writeSignal = 1'b0;

    // reset while running
    resetN = 1'b0;
    #1;
    chk("runrst_cpuRun", 16'(cpuRun), 16'h0);
    chk("runrst_memData", memoryData, 16'h0000);
    chk("runrst_ready", 16'(loadReady), 16'h0);
    #2;
    resetN = 1'b1;
    step();
    chk("reload_ready", 16'(loadReady), 16'h1);
    loadValid = 1'b1;
    loadData  = 16'h1111;
    step();
    loadData  = 16'h2222;
    step();
    loadValid = 1'b0;
    chk("midload_cpuRun", 16'(cpuRun), 16'h0);
    #2;
    resetN = 1'b0;
    #1;
    chk("midrst_ready", 16'(loadReady), 16'h0);
    chk("midrst_cpuRun", 16'(cpuRun), 16'h0);
    chk("midrst_memData", memoryData, 16'h0000);
    #1;
    resetN = 1'b1;
    step();
    loadValid = 1'b1;
    loadData  = 16'hBEEF;
    loadLast  = 1'b1;
    step();
    loadValid = 1'b0;
    loadLast  = 1'b0;
    chk("beef_cpuRun", 16'(cpuRun), 16'h1);
    cpu_read(11'd0);
    chk("beef_mem0", memoryData, 16'hBEEF);
    cpu_read(11'd1);
    chk("beef_mem1_kept", memoryData, 16'h2222);
    cpu_read(11'd2);
    chk("beef_mem2_kept", memoryData, 16'h2007);

    // overflow: 2048 words, no last marker
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
    step();
    for (int i = 0; i < 2048; i++) begin
      loadValid = 1'b1;
      loadData  = 16'(i);
      if (i == 2047) begin
        chk("pre_ovf_cpuRun", 16'(cpuRun), 16'h0);
        chk("pre_ovf_flag", 16'(loadOverflow), 16'h0);
        chk("pre_ovf_ready", 16'(loadReady), 16'h1);
      end
      step();
    end
    chk("ovf_cpuRun", 16'(cpuRun), 16'h1);
    chk("ovf_flag", 16'(loadOverflow), 16'h1);
    chk("ovf_ready", 16'(loadReady), 16'h0);
    loadData = 16'hDEAD;
    step();
    loadValid = 1'b0;
    chk("ovf_refused", 16'(loadReady), 16'h0);
    cpu_read(11'd2047);
    chk("ovf_mem2047", memoryData, 16'h07FF);
    cpu_read(11'd0);
    chk("ovf_mem0", memoryData, 16'h0000);
    cpu_read(11'd5);
    chk("ovf_mem5", memoryData, 16'h0005);
    chk("ovf_sticky", 16'(loadOverflow), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
